// File: rtl/vdp_vram_arb.sv
// VDP VRAM arbiter: the display fetch always owns the port; CPU data-port writes
// and read-ahead prefetches are queued and issued in cycles the display leaves free.
module vdp_vram_arb #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned STARVE_LIMIT = 255
) (
    input  logic              pxclk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [7:0]        disp_rdata,
    input  logic              cpu_addr_ld,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_addr_rd,
    input  logic              cpu_wr_stb,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_rd_stb,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_busy,
    output logic              err_drop,
    output logic              err_late,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND_WR = 2'd1,
        PEND_RD = 2'd2,
        RD_CAP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   wbyte_q, wbyte_d;
    logic [DATA_W-1:0]   rdata_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                drop_d, late_d;
    logic                issue_wr, issue_rd;
    logic [ADDR_W-1:0]   last_addr_q;
    logic                disp_grant_q;

    // A pointer load pre-empts whatever op is queued, so it also blocks that op's issue.
    assign issue_wr = (state_q == PEND_WR) && !disp_req && !cpu_addr_ld;
    assign issue_rd = (state_q == PEND_RD) && !disp_req && !cpu_addr_ld;

    // Next-state, pointer, error and wait-counter logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wbyte_d = wbyte_q;
        rdata_d = cpu_rdata;
        wait_d  = '0;
        drop_d  = err_drop;

        if (state_q == IDLE || cpu_addr_ld) begin
            if (cpu_addr_ld) begin
                ptr_d   = cpu_addr;
                state_d = cpu_addr_rd ? PEND_RD : IDLE;
                if (cpu_wr_stb || cpu_rd_stb) drop_d = 1'b1;
            end else if (cpu_wr_stb) begin
                wbyte_d = cpu_wdata;
                state_d = PEND_WR;
                if (cpu_rd_stb) drop_d = 1'b1;
            end else if (cpu_rd_stb) begin
                state_d = PEND_RD;
            end
        end else begin
            if (cpu_wr_stb || cpu_rd_stb) drop_d = 1'b1;
            case (state_q)
                PEND_WR: begin
                    if (issue_wr) begin
                        rdata_d = wbyte_q;
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = IDLE;
                    end else begin
                        wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
                    end
                end
                PEND_RD: begin
                    if (issue_rd) begin
                        state_d = RD_CAP;
                    end else begin
                        wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
                    end
                end
                RD_CAP: begin
                    rdata_d = mem_rdata;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        late_d = err_late || (wait_d > WAIT_LIMIT);
    end

    // VRAM port: display first, then the queued CPU op, otherwise park on the last address.
    always_comb begin
        mem_addr  = last_addr_q;
        mem_we    = 1'b0;
        mem_wdata = wbyte_q;
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (disp_req) begin
            mem_addr = disp_addr;
        end else if (issue_wr) begin
            mem_addr = ptr_q;
            mem_we   = 1'b1;
        end else if (issue_rd) begin
            mem_addr = ptr_q;
        end
    end

    always_ff @(posedge pxclk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            wbyte_q      <= '0;
            cpu_rdata    <= '0;
            disp_rdata   <= '0;
            cpu_busy     <= 1'b0;
            err_drop     <= 1'b0;
            err_late     <= 1'b0;
            wait_q       <= '0;
            last_addr_q  <= '0;
            disp_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            wbyte_q      <= wbyte_d;
            cpu_rdata    <= rdata_d;
            cpu_busy     <= (state_d != IDLE);
            err_drop     <= drop_d;
            err_late     <= late_d;
            wait_q       <= wait_d;
            last_addr_q  <= mem_addr;
            disp_grant_q <= disp_req;
            if (disp_grant_q) disp_rdata <= mem_rdata;
        end
    end

endmodule
